// File: rtl/io_port_bank.sv
// I/O bank 2: keyboard scan-code FIFO, LED register, millisecond tick counter
// and interrupt enable, on the shared word-addressed CPU bus.
module io_port_bank #(
  parameter int FIFO_DEPTH = 8,
  parameter int CLK_PER_MS = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [3:0]  memWrite,
  input  logic [10:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        key_valid,
  input  logic [7:0]  key_code,
  output logic [7:0]  leds,
  output logic        irq
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int SW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] PRE_MAX = SW'(CLK_PER_MS - 1);

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic [7:0]    r_leds;
  logic [31:0]   r_ms;
  logic [SW-1:0] r_pre;
  logic          r_irq_en;
  logic          r_irq;

  logic       w_sel;
  logic       w_wr;
  logic       w_rd;
  logic [2:0] w_idx;
  logic       w_empty;
  logic       w_full;
  logic       w_pop;
  logic       w_push;
  logic       w_ovf_set;
  logic       w_ovf_clr;

  assign w_sel   = en && (addr[10:3] == 8'd0);
  assign w_idx   = addr[2:0];
  assign w_wr    = w_sel && (memWrite != 4'd0);
  assign w_rd    = w_sel && (memWrite == 4'd0);
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == DEPTH_C);
  assign w_pop   = w_rd && (w_idx == 3'd1) && !w_empty;
  // A full FIFO still accepts a code when the same edge pops the head.
  assign w_push    = key_valid && (!w_full || w_pop);
  assign w_ovf_set = key_valid && w_full && !w_pop;
  assign w_ovf_clr = w_wr && (w_idx == 3'd0) && memWrite[0] && wdata[1];

  always_ff @(posedge clk) begin
    if (rst_n && w_push) r_mem[r_tail] <= key_code;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_leds   <= 8'd0;
      r_ms     <= 32'd0;
      r_pre    <= '0;
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_push) r_tail <= r_tail + PW'(1);
      if (w_pop)  r_head <= r_head + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase

      // Set wins over a same-cycle clear so no overflow event is lost.
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;

      if (w_wr && (w_idx == 3'd2) && memWrite[0]) r_leds <= wdata[7:0];
      if (w_wr && (w_idx == 3'd4) && memWrite[0]) r_irq_en <= wdata[0];

      if (w_wr && (w_idx == 3'd3)) begin
        for (int i = 0; i < 4; i++) begin
          if (memWrite[i]) r_ms[8*i +: 8] <= wdata[8*i +: 8];
        end
        r_pre <= '0;
      end else if (r_pre == PRE_MAX) begin
        r_pre <= '0;
        r_ms  <= r_ms + 32'd1;
      end else begin
        r_pre <= r_pre + SW'(1);
      end

      r_irq <= r_irq_en && !w_empty;
    end
  end

  always_comb begin
    rdata = 32'd0;
    if (w_sel) begin
      case (w_idx)
        3'd0:    rdata = {24'd0, 4'(r_count), 2'b00, r_ovf, !w_empty};
        3'd1:    rdata = w_empty ? 32'd0 : {24'd0, r_mem[r_head]};
        3'd2:    rdata = {24'd0, r_leds};
        3'd3:    rdata = r_ms;
        3'd4:    rdata = {31'd0, r_irq_en};
        default: rdata = 32'd0;
      endcase
    end
  end

  assign leds = r_leds;
  assign irq  = r_irq;
endmodule

// File: tb/tb_io_port_bank.sv
// Directed bench for io_port_bank with a short millisecond period.
module tb_io_port_bank;
  localparam int DEPTH = 8;
  localparam int CPM   = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  memWrite = 4'd0;
  logic [10:0] addr = 11'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        key_valid = 1'b0;
  logic [7:0]  key_code = 8'd0;
  logic [7:0]  leds;
  logic        irq;

  int total = 0;
  int bad = 0;

  io_port_bank #(.FIFO_DEPTH(DEPTH), .CLK_PER_MS(CPM)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .memWrite(memWrite), .addr(addr),
    .wdata(wdata), .rdata(rdata), .key_valid(key_valid), .key_code(key_code),
    .leds(leds), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic peek(input logic [10:0] a, input logic [31:0] exp, input string tag);
    en = 1'b1; memWrite = 4'd0; addr = a;
    #1;
    chk(tag, rdata, exp);
    en = 1'b0;
  endtask

  task automatic wr(input logic [10:0] a, input logic [3:0] be, input logic [31:0] d);
    en = 1'b1; memWrite = be; addr = a; wdata = d;
    step();
    en = 1'b0; memWrite = 4'd0;
  endtask

  task automatic pop(input logic [31:0] exp, input string tag);
    en = 1'b1; memWrite = 4'd0; addr = 11'd1;
    #1;
    chk(tag, rdata, exp);
    step();
    en = 1'b0;
  endtask

  task automatic push(input logic [7:0] code);
    key_valid = 1'b1; key_code = code;
    step();
    key_valid = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_leds", {24'd0, leds}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    rst_n = 1'b1;
    peek(11'd0, 32'd0, "rst_status");
    peek(11'd1, 32'd0, "rst_keydata");
    peek(11'd2, 32'd0, "rst_leds_reg");
    peek(11'd3, 32'd0, "rst_mscount");
    peek(11'd4, 32'd0, "rst_ctrl");

    // Tick counter: write clears the prescaler, three periods give 3.
    wr(11'd3, 4'hF, 32'd0);
    repeat (3 * CPM - 1) step();
    peek(11'd3, 32'd2, "ms_before_3rd");
    step();
    peek(11'd3, 32'd3, "ms_after_3rd");
    peek(11'h008, 32'd0, "undecoded");
    peek(11'd5, 32'd0, "idx5");

    push(8'h1C);
    push(8'h32);
    peek(11'd0, 32'h21, "status_two");
    pop(32'h1C, "pop_1c");
    pop(32'h32, "pop_32");
    pop(32'h0, "pop_empty");
    peek(11'd0, 32'h00, "status_drained");

    // Push and read on an empty FIFO: read sees 0, entry lands.
    key_valid = 1'b1; key_code = 8'h77; en = 1'b1; addr = 11'd1; memWrite = 4'd0;
    #1;
    chk("empty_push_read", rdata, 32'd0);
    step();
    key_valid = 1'b0; en = 1'b0;
    peek(11'd0, 32'h11, "status_one");
    pop(32'h77, "pop_77");

    for (int i = 1; i <= DEPTH + 1; i++) push(8'(i));
    peek(11'd0, 32'h83, "status_ovf");
    wr(11'd0, 4'h1, 32'h2);
    peek(11'd0, 32'h81, "status_ovf_clr");

    // Full FIFO, push with simultaneous pop.
    key_valid = 1'b1; key_code = 8'h0A; en = 1'b1; addr = 11'd1; memWrite = 4'd0;
    #1;
    chk("full_pushpop_head", rdata, 32'h01);
    step();
    key_valid = 1'b0; en = 1'b0;
    peek(11'd0, 32'h81, "status_full_pushpop");
    for (int i = 2; i <= DEPTH; i++) pop(32'(i), "drain");
    pop(32'h0A, "drain_last");
    peek(11'd0, 32'h00, "status_after_drain");

    // No state change and zero read data while deselected.
    en = 1'b0; addr = 11'd2; memWrite = 4'h1; wdata = 32'h55;
    step();
    memWrite = 4'd0;
    chk("en0_leds", {24'd0, leds}, 32'd0);
    addr = 11'd3;
    #1;
    chk("en0_rdata", rdata, 32'd0);

    wr(11'd2, 4'h1, 32'h0000_00AB);
    chk("leds_ab", {24'd0, leds}, 32'hAB);
    wr(11'd2, 4'hE, 32'hFFFF_FFFF);
    chk("leds_upper_lanes", {24'd0, leds}, 32'hAB);
    peek(11'd2, 32'hAB, "leds_read");

    wr(11'd3, 4'hF, 32'h1234_5678);
    peek(11'd3, 32'h1234_5678, "ms_full_write");
    wr(11'd3, 4'h2, 32'h0000_AB00);
    peek(11'd3, 32'h1234_AB78, "ms_lane_merge");
    wr(11'd3, 4'hF, 32'hFFFF_FFFF);
    repeat (CPM - 1) step();
    peek(11'd3, 32'hFFFF_FFFF, "ms_pre_wrap");
    step();
    peek(11'd3, 32'd0, "ms_wrap");

    wr(11'd4, 4'h1, 32'hFFFF_FFFF);
    peek(11'd4, 32'd1, "ctrl_read");
    chk("irq_idle", {31'd0, irq}, 32'd0);
    push(8'h5A);
    chk("irq_same_edge", {31'd0, irq}, 32'd0);
    step();
    chk("irq_set", {31'd0, irq}, 32'd1);
    pop(32'h5A, "pop_5a");
    chk("irq_hold", {31'd0, irq}, 32'd1);
    step();
    chk("irq_clear", {31'd0, irq}, 32'd0);

    // Overflow clear and new overflow in the same cycle.
    for (int i = 0; i < DEPTH; i++) push(8'(8'h10 + i));
    peek(11'd0, 32'h81, "status_full");
    key_valid = 1'b1; key_code = 8'h99;
    wr(11'd0, 4'h1, 32'h2);
    key_valid = 1'b0;
    peek(11'd0, 32'h83, "ovf_set_wins");
    chk("irq_full", {31'd0, irq}, 32'd1);

    // Reset asserted mid-read.
    en = 1'b1; addr = 11'd1; memWrite = 4'd0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_leds", {24'd0, leds}, 32'd0);
    chk("arst_irq", {31'd0, irq}, 32'd0);
    chk("arst_keydata", rdata, 32'd0);
    step();
    chk("arst_hold_keydata", rdata, 32'd0);
    addr = 11'd0; #1; chk("arst_status", rdata, 32'd0);
    addr = 11'd3; #1; chk("arst_ms", rdata, 32'd0);
    addr = 11'd4; #1; chk("arst_ctrl", rdata, 32'd0);
    en = 1'b0;
    rst_n = 1'b1;
    step();
    peek(11'd0, 32'd0, "post_rst_status");
    peek(11'd2, 32'd0, "post_rst_leds");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
